// File: rtl/wb_slave_responder.sv
// ============================================================================
// Module      : wb_slave_responder
// Description : Wishbone B3 classic slave with a word memory, programmable
//               wait states, err window and periodic rty injection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_slave_responder #(
  parameter int             DW          = 32,
  parameter int             AW          = 32,
  parameter int             MEM_AW      = 8,
  parameter int             WAIT_STATES = 1,
  parameter logic [AW-1:0]  ERR_BASE    = 32'hF000_0000,
  parameter logic [AW-1:0]  ERR_MASK    = 32'hF000_0000,
  parameter int             RTY_EVERY   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [DW/8-1:0]   wb_sel_i,
  input  logic [AW-1:0]     wb_adr_i,
  input  logic [DW-1:0]     wb_dat_i,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_rty_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [15:0]       xfer_count_o,
  output logic [15:0]       err_count_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int          c_nbytes    = DW / 8;
  localparam int          c_depth     = 1 << MEM_AW;
  localparam logic [3:0]  c_wait_load = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [15:0] c_rty_last  = 16'((RTY_EVERY > 0) ? RTY_EVERY - 1 : 0);

  logic [1:0]          r_state;
  logic [3:0]          r_wait_cnt;
  logic [15:0]         r_rty_cnt;
  logic [MEM_AW-1:0]   r_idx;
  logic                r_we;
  logic [c_nbytes-1:0] r_sel;
  logic [DW-1:0]       r_dat;
  logic                r_is_err;
  logic                r_is_rty;
  logic [15:0]         r_xfer_count;
  logic [15:0]         r_err_count;
  logic [DW-1:0]       r_mem [0:c_depth-1];

  logic w_req;
  logic w_in_err;
  logic w_rty_hit;
  logic w_do_ack;

  assign w_req     = wb_cyc_i & wb_stb_i;
  assign w_in_err  = (ERR_MASK != '0) && ((wb_adr_i & ERR_MASK) == ERR_BASE);
  assign w_rty_hit = (RTY_EVERY > 0) && (r_rty_cnt == c_rty_last);
  assign w_do_ack  = (r_state == S_RESP) && !r_is_err && !r_is_rty;

  assign xfer_count_o = r_xfer_count;
  assign err_count_o  = r_err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= 4'd0;
      r_rty_cnt    <= 16'd0;
      r_idx        <= '0;
      r_we         <= 1'b0;
      r_sel        <= '0;
      r_dat        <= '0;
      r_is_err     <= 1'b0;
      r_is_rty     <= 1'b0;
      r_xfer_count <= 16'd0;
      r_err_count  <= 16'd0;
      wb_ack_o     <= 1'b0;
      wb_err_o     <= 1'b0;
      wb_rty_o     <= 1'b0;
      wb_dat_o     <= '0;
    end else begin
      // Termination strobes are single-cycle pulses by construction.
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_rty_o <= 1'b0;
      wb_dat_o <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_idx      <= wb_adr_i[MEM_AW+1:2];
            r_we       <= wb_we_i;
            r_sel      <= wb_sel_i;
            r_dat      <= wb_dat_i;
            r_is_err   <= w_in_err;
            r_is_rty   <= !w_in_err && w_rty_hit;
            r_wait_cnt <= c_wait_load;
            // Only non-error accepts advance the retry cadence.
            if (!w_in_err && (RTY_EVERY > 0)) begin
              r_rty_cnt <= w_rty_hit ? 16'd0 : r_rty_cnt + 16'd1;
            end
            r_state <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!wb_cyc_i) begin
            r_state <= S_IDLE;
          end else if (r_wait_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          if (r_is_err) begin
            wb_err_o <= 1'b1;
            if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
          end else if (r_is_rty) begin
            wb_rty_o <= 1'b1;
          end else begin
            wb_ack_o <= 1'b1;
            if (r_xfer_count != 16'hFFFF) r_xfer_count <= r_xfer_count + 16'd1;
            if (!r_we) wb_dat_o <= r_mem[r_idx];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_ack && r_we) begin
      for (int i = 0; i < c_nbytes; i++) begin
        if (r_sel[i]) r_mem[r_idx][i*8 +: 8] <= r_dat[i*8 +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_slave_responder.sv
// ============================================================================
// Module      : tb_wb_slave_responder
// Description : Directed self-checking bench for wb_slave_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_slave_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc  [4];
  logic        stb  [4];
  logic        we   [4];
  logic [3:0]  sel  [4];
  logic [31:0] adr  [4];
  logic [31:0] wdat [4];
  logic        ack  [4];
  logic        err  [4];
  logic        rty  [4];
  logic [31:0] rdat [4];
  logic [15:0] xcnt [4];
  logic [15:0] ecnt [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // 0: W=1 err window; 1: W=1 rty every 3; 2: W=3; 3: W=0
  for (genvar i = 0; i < 4; i++) begin : g_dut
    localparam int WS = (i == 2) ? 3 : ((i == 3) ? 0 : 1);
    localparam int RT = (i == 1) ? 3 : 0;
    wb_slave_responder #(
      .DW(32), .AW(32), .MEM_AW(8), .WAIT_STATES(WS),
      .ERR_BASE(32'hF000_0000), .ERR_MASK(32'hF000_0000), .RTY_EVERY(RT)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .wb_cyc_i(cyc[i]), .wb_stb_i(stb[i]), .wb_we_i(we[i]),
      .wb_sel_i(sel[i]), .wb_adr_i(adr[i]), .wb_dat_i(wdat[i]),
      .wb_ack_o(ack[i]), .wb_err_o(err[i]), .wb_rty_o(rty[i]),
      .wb_dat_o(rdat[i]), .xfer_count_o(xcnt[i]), .err_count_o(ecnt[i])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // kind: 0 ack, 1 err, 2 rty, 3 no response
  task automatic xfer(input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] dat, input logic [3:0] s, input int ws,
                      output logic [1:0] kind, output logic [31:0] rd);
    int n;
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = dat; sel[d] = s;
    n = 0; kind = 2'd3; rd = '0;
    while (n < 20 && kind == 2'd3) begin
      @(negedge clk);
      n++;
      if (ack[d] | err[d] | rty[d]) begin
        kind = ack[d] ? 2'd0 : (err[d] ? 2'd1 : 2'd2);
        rd   = rdat[d];
        check($sformatf("onehot[%0d]", d), 32'(ack[d]) + 32'(err[d]) + 32'(rty[d]), 32'd1);
      end
    end
    check($sformatf("latency[%0d] %h", d, a), 32'(n), 32'(ws + 2));
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    @(negedge clk);
    check($sformatf("single_cycle[%0d]", d), {29'd0, ack[d], err[d], rty[d]}, 32'd0);
  endtask

  logic [1:0]  k;
  logic [31:0] rd;
  int          cnt;
  logic [5:0]  mask;
  logic [1:0]  exp_kind [10] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2};
  logic [31:0] b_adr    [10] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C,
                                 32'hF000_0000, 32'h20};

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc[i] = 0; stb[i] = 0; we[i] = 0; sel[i] = '0; adr[i] = '0; wdat[i] = '0;
    end
    repeat (2) @(negedge clk);
    check("reset_ack", {31'd0, ack[0]}, 32'd0);
    check("reset_xcnt", {16'd0, xcnt[0]}, 32'd0);
    rst_n = 1'b1;

    // Write/read with byte merge
    xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1, k, rd);
    check("wr1_kind", {30'd0, k}, 32'd0);
    check("wr1_dat0", rd, 32'd0);
    xfer(0, 1'b1, 32'h10, 32'h0000_0055, 4'h1, 1, k, rd);
    check("wr2_kind", {30'd0, k}, 32'd0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1, k, rd);
    check("rd_kind", {30'd0, k}, 32'd0);
    check("rd_data", rd, 32'hDEAD_BE55);
    check("xcnt3", {16'd0, xcnt[0]}, 32'd3);

    // Error window
    xfer(0, 1'b0, 32'hF000_0004, 32'h0, 4'hF, 1, k, rd);
    check("err_kind", {30'd0, k}, 32'd1);
    check("err_dat0", rd, 32'd0);
    check("ecnt1", {16'd0, ecnt[0]}, 32'd1);
    xfer(0, 1'b1, 32'hF000_0010, 32'h1234_5678, 4'hF, 1, k, rd);
    check("errwr_kind", {30'd0, k}, 32'd1);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1, k, rd);
    check("alias_data", rd, 32'hDEAD_BE55);
    check("xcnt4", {16'd0, xcnt[0]}, 32'd4);
    check("ecnt2", {16'd0, ecnt[0]}, 32'd2);

    // Reset asserted while the slave sits in WAIT
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h10;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_resp", {29'd0, ack[0], err[0], rty[0]}, 32'd0);
    check("arst_dat", rdat[0], 32'd0);
    check("arst_xcnt", {16'd0, xcnt[0]}, 32'd0);
    check("arst_ecnt", {16'd0, ecnt[0]}, 32'd0);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack[0] | err[0] | rty[0]) cnt++;
    end
    check("no_stale_resp", 32'(cnt), 32'd0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1, k, rd);
    check("post_rst_data", rd, 32'hDEAD_BE55);
    check("post_rst_xcnt", {16'd0, xcnt[0]}, 32'd1);

    // Retry cadence, with an err interleaved that must not advance it
    for (int i = 0; i < 10; i++) begin
      xfer(1, 1'b0, b_adr[i], 32'h0, 4'hF, 1, k, rd);
      check($sformatf("rty_seq%0d", i), {30'd0, k}, {30'd0, exp_kind[i]});
      if (i == 4) check("rty_xcnt4", {16'd0, xcnt[1]}, 32'd4);
    end
    check("rty_xcnt6", {16'd0, xcnt[1]}, 32'd6);
    check("rty_ecnt1", {16'd0, ecnt[1]}, 32'd1);

    // Abort during WAIT (W=3)
    xfer(2, 1'b1, 32'h20, 32'hA5A5_A5A5, 4'hF, 3, k, rd);
    check("abt_pre_kind", {30'd0, k}, 32'd0);
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h20; wdat[2] = 32'h5A5A_5A5A;
    @(negedge clk);
    cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack[2] | err[2] | rty[2]) cnt++;
    end
    check("abt_noresp", 32'(cnt), 32'd0);
    check("abt_xcnt", {16'd0, xcnt[2]}, 32'd1);
    check("abt_ecnt", {16'd0, ecnt[2]}, 32'd0);
    xfer(2, 1'b0, 32'h20, 32'h0, 4'hF, 3, k, rd);
    check("abt_mem", rd, 32'hA5A5_A5A5);

    // Zero wait states, stb held across three reads
    xfer(3, 1'b1, 32'h0, 32'h0000_0011, 4'hF, 0, k, rd);
    check("zw_wr_kind", {30'd0, k}, 32'd0);
    @(negedge clk);
    cyc[3] = 1'b1; stb[3] = 1'b1; we[3] = 1'b0; adr[3] = 32'h0;
    mask = '0; rd = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mask[i] = ack[3];
      if (ack[3]) rd = rdat[3];
    end
    cyc[3] = 1'b0; stb[3] = 1'b0;
    check("b2b_pattern", {26'd0, mask}, 32'h2A);
    check("b2b_data", rd, 32'h0000_0011);
    check("b2b_xcnt", {16'd0, xcnt[3]}, 32'd4);

    // Saturation
    @(negedge clk);
    force g_dut[3].u_dut.r_xfer_count = 16'hFFFE;
    #1;
    release g_dut[3].u_dut.r_xfer_count;
    xfer(3, 1'b0, 32'h0, 32'h0, 4'hF, 0, k, rd);
    check("sat_1", {16'd0, xcnt[3]}, 32'h0000_FFFF);
    xfer(3, 1'b0, 32'h0, 32'h0, 4'hF, 0, k, rd);
    check("sat_2", {16'd0, xcnt[3]}, 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
